cordic_iter_core: RTL and testbench

CORDIC_ITER_CORE -- requirements
Module: cordic_iter_core

---
 rtl/cordic_iter_core.sv | 228 ++++++++++++++++++++++
 tb/tb_cordic_iter_core.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter_core.sv
// Iterative CORDIC core: one micro-rotation per clock, rotation or vectoring mode.
// Optional quadrant pre-rotation enabled by defining CORDIC_QUAD_EXT_EN.
module cordic_iter_core #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITERS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic             io_in_mode,
  input  logic [WIDTH-1:0] io_in_x,
  input  logic [WIDTH-1:0] io_in_y,
  input  logic [WIDTH-1:0] io_in_z,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_x,
  output logic [WIDTH-1:0] io_out_y,
  output logic [WIDTH-1:0] io_out_z
);

  localparam int unsigned XW = WIDTH + 2;

  localparam logic [1:0] StIdle = 2'd0;
`ifdef CORDIC_QUAD_EXT_EN
  localparam logic [1:0] StPre  = 2'd1;
  localparam logic [WIDTH-1:0] HalfPi = {2'b01, {(WIDTH-2){1'b0}}};
`endif
  localparam logic [1:0] StIter = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [5:0] LastIter = 6'(ITERS - 1);

  localparam logic signed [XW-1:0] SatMax = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] SatMin = {3'b111, {(WIDTH-1){1'b0}}};

  logic [1:0]              state_q, state_d;
  logic                    mode_q;
  logic signed [XW-1:0]    x_q, y_q;
  logic [WIDTH-1:0]        z_q;
  logic [5:0]              iter_q;
  logic [WIDTH-1:0]        out_x_q, out_y_q, out_z_q;

  logic                    in_fire;
  logic                    d_pos;
  logic signed [XW-1:0]    x_sh, y_sh, rot_x, rot_y;
  logic [WIDTH-1:0]        rot_z;
  logic signed [31:0]      atan_full;
  logic [WIDTH-1:0]        atan_w;

  // atan(2^-i) scaled so that 2^32 spans a full turn
  function automatic logic [31:0] atan_lut(input logic [4:0] i);
    logic [31:0] v;
    unique case (i)
      5'd0:  v = 32'h20000000;
      5'd1:  v = 32'h12E4051E;
      5'd2:  v = 32'h09FB385B;
      5'd3:  v = 32'h051111D4;
      5'd4:  v = 32'h028B0D43;
      5'd5:  v = 32'h0145D7E1;
      5'd6:  v = 32'h00A2F61E;
      5'd7:  v = 32'h00517C55;
      5'd8:  v = 32'h0028BE53;
      5'd9:  v = 32'h00145F2F;
      5'd10: v = 32'h000A2F98;
      5'd11: v = 32'h000517CC;
      5'd12: v = 32'h00028BE6;
      5'd13: v = 32'h000145F3;
      5'd14: v = 32'h0000A2FA;
      5'd15: v = 32'h0000517D;
      5'd16: v = 32'h000028BE;
      5'd17: v = 32'h0000145F;
      5'd18: v = 32'h00000A30;
      5'd19: v = 32'h00000518;
      5'd20: v = 32'h0000028C;
      5'd21: v = 32'h00000146;
      5'd22: v = 32'h000000A3;
      5'd23: v = 32'h00000051;
      5'd24: v = 32'h00000029;
      5'd25: v = 32'h00000014;
      5'd26: v = 32'h0000000A;
      5'd27: v = 32'h00000005;
      5'd28: v = 32'h00000003;
      5'd29: v = 32'h00000001;
      5'd30: v = 32'h00000001;
      default: v = 32'h00000000;
    endcase
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
    logic [WIDTH-1:0] r;
    if (v > SatMax) begin
      r = SatMax[WIDTH-1:0];
    end else if (v < SatMin) begin
      r = SatMin[WIDTH-1:0];
    end else begin
      r = v[WIDTH-1:0];
    end
    return r;
  endfunction

  assign in_fire      = io_in_valid && (state_q == StIdle);
  assign io_in_ready  = (state_q == StIdle);
  assign io_out_valid = (state_q == StDone);
  assign io_out_x     = out_x_q;
  assign io_out_y     = out_y_q;
  assign io_out_z     = out_z_q;

  always_comb begin
    atan_full = $signed(atan_lut(iter_q[4:0]));
    atan_w    = WIDTH'(atan_full >>> (32 - WIDTH));
    x_sh      = x_q >>> iter_q;
    y_sh      = y_q >>> iter_q;
    // Rotation drives z toward 0, vectoring drives y toward 0
    d_pos     = mode_q ? y_q[XW-1] : ~z_q[WIDTH-1];
    if (d_pos) begin
      rot_x = x_q - y_sh;
      rot_y = y_q + x_sh;
      rot_z = z_q - atan_w;
    end else begin
      rot_x = x_q + y_sh;
      rot_y = y_q - x_sh;
      rot_z = z_q + atan_w;
    end
  end

`ifdef CORDIC_QUAD_EXT_EN
  logic signed [XW-1:0] pre_x, pre_y;
  logic [WIDTH-1:0]     pre_z;

  // Fold the operand into the right half-plane before iterating
  always_comb begin
    pre_x = x_q;
    pre_y = y_q;
    pre_z = z_q;
    if (!mode_q) begin
      if (z_q[WIDTH-1:WIDTH-2] == 2'b01) begin
        pre_x = -y_q;
        pre_y = x_q;
        pre_z = z_q - HalfPi;
      end else if (z_q[WIDTH-1:WIDTH-2] == 2'b10) begin
        pre_x = y_q;
        pre_y = -x_q;
        pre_z = z_q + HalfPi;
      end
    end else if (x_q[XW-1]) begin
      if (!y_q[XW-1]) begin
        pre_x = y_q;
        pre_y = -x_q;
        pre_z = z_q + HalfPi;
      end else begin
        pre_x = -y_q;
        pre_y = x_q;
        pre_z = z_q - HalfPi;
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_fire) begin
`ifdef CORDIC_QUAD_EXT_EN
          state_d = StPre;
`else
          state_d = StIter;
`endif
        end
      end
`ifdef CORDIC_QUAD_EXT_EN
      StPre:  state_d = StIter;
`endif
      StIter: if (iter_q == LastIter) state_d = StDone;
      StDone: if (io_out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      out_x_q <= '0;
      out_y_q <= '0;
      out_z_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (in_fire) begin
            mode_q <= io_in_mode;
            x_q    <= {{2{io_in_x[WIDTH-1]}}, io_in_x};
            y_q    <= {{2{io_in_y[WIDTH-1]}}, io_in_y};
            z_q    <= io_in_z;
            iter_q <= '0;
          end
        end
`ifdef CORDIC_QUAD_EXT_EN
        StPre: begin
          x_q <= pre_x;
          y_q <= pre_y;
          z_q <= pre_z;
        end
`endif
        StIter: begin
          x_q    <= rot_x;
          y_q    <= rot_y;
          z_q    <= rot_z;
          iter_q <= iter_q + 6'd1;
          if (iter_q == LastIter) begin
            out_x_q <= sat(rot_x);
            out_y_q <= sat(rot_y);
            out_z_q <= rot_z;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_core.sv
// Directed bench for cordic_iter_core (WIDTH = ITERS = 16), with extra quadrant
// vectors when CORDIC_QUAD_EXT_EN is defined.
module tb_cordic_iter_core;

`ifdef CORDIC_QUAD_EXT_EN
  localparam int ExpLat = 17;
`else
  localparam int ExpLat = 16;
`endif
  localparam int Tol = 4;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               io_in_valid = 1'b0;
  logic               io_in_ready;
  logic               io_in_mode = 1'b0;
  logic signed [15:0] io_in_x = '0;
  logic signed [15:0] io_in_y = '0;
  logic signed [15:0] io_in_z = '0;
  logic               io_out_valid;
  logic               io_out_ready = 1'b0;
  logic signed [15:0] io_out_x, io_out_y, io_out_z;

  int checks = 0;
  int errors = 0;
  int lat;

  cordic_iter_core #(.WIDTH(16), .ITERS(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_mode   (io_in_mode),
    .io_in_x      (io_in_x),
    .io_in_y      (io_in_y),
    .io_in_z      (io_in_z),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_x     (io_out_x),
    .io_out_y     (io_out_y),
    .io_out_z     (io_out_z)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp, input int tol);
    int diff;
    checks++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Present an operand, wait for the accept edge, then count edges until io_out_valid
  task automatic start_op(input logic mode, input int x, input int y, input int z,
                          output int cycles);
    @(negedge clock);
    check("in_ready_before_op", int'(io_in_ready), 1, 0);
    io_in_valid = 1'b1;
    io_in_mode  = mode;
    io_in_x     = 16'(x);
    io_in_y     = 16'(y);
    io_in_z     = 16'(z);
    @(posedge clock);
    #1;
    io_in_valid = 1'b0;
    cycles = 0;
    while (!io_out_valid && cycles < 200) begin
      @(posedge clock);
      #1;
      cycles++;
    end
  endtask

  task automatic release_result();
    @(negedge clock);
    io_out_ready = 1'b1;
    @(posedge clock);
    #1;
    io_out_ready = 1'b0;
    check("valid_after_release", int'(io_out_valid), 0, 0);
    check("ready_after_release", int'(io_in_ready), 1, 0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", int'(io_out_valid), 0, 0);
    check("rst_out_x", int'(io_out_x), 0, 0);
    check("rst_out_y", int'(io_out_y), 0, 0);
    check("rst_out_z", int'(io_out_z), 0, 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("rst_in_ready", int'(io_in_ready), 1, 0);

    // Rotation by 0: gain-scaled x only
    start_op(1'b0, 9949, 0, 0, lat);
    check("rot0_latency", lat, ExpLat, 0);
    check("rot0_x", int'(io_out_x), 16384, Tol);
    check("rot0_y", int'(io_out_y), 0, Tol);
    check("rot0_z", int'(io_out_z), 0, Tol);
    release_result();

    // Rotation by pi/4 with result held under backpressure
    start_op(1'b0, 9949, 0, 8192, lat);
    check("rot45_latency", lat, ExpLat, 0);
    check("rot45_x", int'(io_out_x), 11585, Tol);
    check("rot45_y", int'(io_out_y), 11585, Tol);
    check("rot45_z", int'(io_out_z), 0, Tol);
    repeat (5) begin
      @(negedge clock);
      check("hold_valid", int'(io_out_valid), 1, 0);
      check("hold_in_ready", int'(io_in_ready), 0, 0);
      check("hold_x", int'(io_out_x), 11585, Tol);
      check("hold_y", int'(io_out_y), 11585, Tol);
    end
    // Operand offered on the release edge must not be taken
    @(negedge clock);
    io_out_ready = 1'b1;
    io_in_valid  = 1'b1;
    io_in_mode   = 1'b0;
    io_in_x      = 16'sd100;
    io_in_y      = 16'sd0;
    io_in_z      = 16'sd0;
    @(posedge clock);
    #1;
    io_out_ready = 1'b0;
    check("release_valid", int'(io_out_valid), 0, 0);
    check("release_no_accept", int'(io_in_ready), 1, 0);
    @(negedge clock);
    io_in_valid = 1'b0;
    @(posedge clock);
    #1;
    check("release_still_idle", int'(io_in_ready), 1, 0);

    // Vectoring at 45 degrees: magnitude and angle
    start_op(1'b1, 8192, 8192, 0, lat);
    check("vec45_latency", lat, ExpLat, 0);
    check("vec45_x", int'(io_out_x), 19079, Tol);
    check("vec45_y", int'(io_out_y), 0, Tol);
    check("vec45_z", int'(io_out_z), 8192, Tol);
    release_result();

    // Magnitude beyond range saturates to the positive limit
    start_op(1'b1, 32767, 32767, 0, lat);
    check("vecsat_x", int'(io_out_x), 32767, 0);
    check("vecsat_y", int'(io_out_y), 0, Tol);
    check("vecsat_z", int'(io_out_z), 8192, Tol);
    release_result();

    // Rotation by -pi/2 saturates y to the negative limit
    start_op(1'b0, 32767, 0, -16384, lat);
    check("rotsat_y", int'(io_out_y), -32768, 0);
    check("rotsat_z", int'(io_out_z), 0, Tol);
    release_result();

    // Reset in the middle of iteration 7
    @(negedge clock);
    io_in_valid = 1'b1;
    io_in_mode  = 1'b0;
    io_in_x     = 16'sd9949;
    io_in_y     = 16'sd0;
    io_in_z     = 16'sd8192;
    @(posedge clock);
    #1;
    io_in_valid = 1'b0;
    repeat (ExpLat - 9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midrst_valid", int'(io_out_valid), 0, 0);
    check("midrst_x", int'(io_out_x), 0, 0);
    check("midrst_y", int'(io_out_y), 0, 0);
    check("midrst_z", int'(io_out_z), 0, 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_in_ready", int'(io_in_ready), 1, 0);
    check("midrst_no_result", int'(io_out_valid), 0, 0);
    start_op(1'b0, 9949, 0, 8192, lat);
    check("postrst_latency", lat, ExpLat, 0);
    check("postrst_x", int'(io_out_x), 11585, Tol);
    check("postrst_y", int'(io_out_y), 11585, Tol);
    release_result();

`ifdef CORDIC_QUAD_EXT_EN
    // Rotation by 3pi/4 needs the quadrant pre-rotation
    start_op(1'b0, 9949, 0, 24576, lat);
    check("rot135_latency", lat, 17, 0);
    check("rot135_x", int'(io_out_x), -11585, Tol);
    check("rot135_y", int'(io_out_y), 11585, Tol);
    release_result();

    // Vectoring from the second quadrant
    start_op(1'b1, -8192, 8192, 0, lat);
    check("vec135_x", int'(io_out_x), 19079, Tol);
    check("vec135_y", int'(io_out_y), 0, Tol);
    check("vec135_z", int'(io_out_z), 24576, Tol);
    release_result();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
